// File: rtl/vadd_fp16.sv
// Registered IEEE-754 binary16 adder with overflow flag; VADD_SAT_EN selects saturation to max finite on overflow.
// Latency: 1 cycle, one add accepted every clock.
// Backpressure: none; A and B are sampled on every rising Clk.
module vadd_fp16 (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum,
  output logic        Overflow
);

  function automatic logic [3:0] lzc14(input logic [13:0] v);
    lzc14 = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) lzc14 = 4'(13 - i);
    end
  endfunction

  logic        sa, sb;
  logic [4:0]  xa, xb;
  logic [9:0]  fa, fb;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        a_big, eff_sub;

  logic        sl;
  logic [4:0]  xl, xs, el, es, d;
  logic [10:0] ml, ms;
  logic [45:0] shf;
  logic [13:0] aligned;
  logic [14:0] mag;
  logic [3:0]  lz;
  logic [4:0]  lshift;
  logic [13:0] norm;
  logic [6:0]  en, fld;
  logic        rnd_up;
  logic [11:0] rm;
  logic [9:0]  frac;
  logic        rs, ovf;
  logic [15:0] nxt_sum;
  logic        nxt_ovf;

  assign {sa, xa, fa} = A;
  assign {sb, xb, fb} = B;
  assign nan_a   = (xa == 5'h1f) && (fa != 10'd0);
  assign nan_b   = (xb == 5'h1f) && (fb != 10'd0);
  assign inf_a   = (xa == 5'h1f) && (fa == 10'd0);
  assign inf_b   = (xb == 5'h1f) && (fb == 10'd0);
  assign a_big   = A[14:0] >= B[14:0];
  assign eff_sub = sa ^ sb;

  // Larger magnitude first; subnormals use effective exponent 1 and hidden bit 0.
  always_comb begin
    sl = a_big ? sa : sb;
    xl = a_big ? xa : xb;
    xs = a_big ? xb : xa;
    ml = a_big ? {xa != 5'd0, fa} : {xb != 5'd0, fb};
    ms = a_big ? {xb != 5'd0, fb} : {xa != 5'd0, fa};
    el = (xl == 5'd0) ? 5'd1 : xl;
    es = (xs == 5'd0) ? 5'd1 : xs;
    d  = el - es;
  end

  // Three extra low bits hold guard/round/sticky; everything shifted past them folds into sticky.
  assign shf     = {ms, 35'd0} >> d;
  assign aligned = shf[45:32] | {13'd0, |shf[31:0]};
  assign mag     = eff_sub ? ({1'b0, ml, 3'b000} - {1'b0, aligned})
                           : ({1'b0, ml, 3'b000} + {1'b0, aligned});
  assign lz      = lzc14(mag[13:0]);

  always_comb begin
    lshift = 5'd0;
    norm   = 14'd0;
    en     = 7'd0;
    if (mag[14]) begin
      norm = {mag[14:2], mag[1] | mag[0]};
      en   = {2'b00, el} + 7'd1;
    end else begin
      // Left shift stops at exponent 1 so tiny results come out subnormal.
      lshift = ({1'b0, lz} > (el - 5'd1)) ? (el - 5'd1) : {1'b0, lz};
      norm   = mag[13:0] << lshift;
      en     = {2'b00, el} - {2'b00, lshift};
    end
  end

  assign rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
  assign rm     = {1'b0, norm[13:3]} + {11'd0, rnd_up};

  always_comb begin
    fld  = 7'd0;
    frac = rm[9:0];
    if (rm[11]) begin
      fld  = en + 7'd1;
      frac = 10'd0;
    end else if (rm[10]) begin
      fld  = en;
    end
  end

  // Exact cancellation yields +0; only same-sign zero addition keeps the sign.
  assign rs  = (mag == 15'd0) ? (eff_sub ? 1'b0 : sl) : sl;
  assign ovf = fld >= 7'd31;

  always_comb begin
    nxt_sum = {rs, fld[4:0], frac};
    nxt_ovf = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
      nxt_sum = 16'h7e00;
    end else if (inf_a) begin
      nxt_sum = A;
    end else if (inf_b) begin
      nxt_sum = B;
    end else if (ovf) begin
      nxt_ovf = 1'b1;
`ifdef VADD_SAT_EN
      nxt_sum = {rs, 15'h7bff};
`else
      nxt_sum = {rs, 15'h7c00};
`endif
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Sum      <= 16'h0000;
      Overflow <= 1'b0;
    end else begin
      Sum      <= nxt_sum;
      Overflow <= nxt_ovf;
    end
  end

endmodule

// File: tb/tb_vadd_fp16.sv
// Directed bench for vadd_fp16: expected results queued at issue, compared one edge later.
module tb_vadd_fp16;

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
    string       tag;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic [15:0] Sum;
  logic        Overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

`ifdef VADD_SAT_EN
  localparam logic [15:0] POS_OVF = 16'h7bff;
  localparam logic [15:0] NEG_OVF = 16'hfbff;
`else
  localparam logic [15:0] POS_OVF = 16'h7c00;
  localparam logic [15:0] NEG_OVF = 16'hfc00;
`endif

  vadd_fp16 dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .A        (A),
    .B        (B),
    .Sum      (Sum),
    .Overflow (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed sum=%h ovf=%b, expected sum=%h ovf=%b",
             tag, obs[16:1], obs[0], expv[16:1], expv[0]);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed sum=%h, expected an entry", Sum);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, {Sum, Overflow}, {e.sum, e.ovf});
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] es, input logic eo, input string tag);
    exp_t e;
    @(negedge Clk);
    A = a;
    B = b;
    e.sum = es;
    e.ovf = eo;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    compare_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    #2 Rst = 1'b1;
    #1 check("reset_async", {Sum, Overflow}, {16'h0000, 1'b0});
    @(posedge Clk);
    @(posedge Clk);
    #1 check("reset_hold", {Sum, Overflow}, {16'h0000, 1'b0});
    @(negedge Clk);
    Rst = 1'b0;

    issue(16'h3c00, 16'h3c00, 16'h4000, 1'b0, "one_plus_one");
    issue(16'h4000, 16'h4000, 16'h4400, 1'b0, "two_plus_two");
    issue(16'h7bff, 16'h7bff, POS_OVF,  1'b1, "overflow_pos");
    issue(16'h3c00, 16'h0000, 16'h3c00, 1'b0, "overflow_clears");
    issue(16'hfbff, 16'hfbff, NEG_OVF,  1'b1, "overflow_neg");
    issue(16'h7bff, 16'h4c00, POS_OVF,  1'b1, "overflow_by_rounding");
    issue(16'h7bff, 16'h4bff, 16'h7bff, 1'b0, "max_no_overflow");
    issue(16'h3c00, 16'hbc00, 16'h0000, 1'b0, "cancel");
    issue(16'h3c00, 16'h0001, 16'h3c00, 1'b0, "rounded_away");
    issue(16'h3c00, 16'h1400, 16'h3c01, 1'b0, "one_ulp");
    issue(16'h3c00, 16'h1000, 16'h3c00, 1'b0, "tie_even_down");
    issue(16'h3c01, 16'h1000, 16'h3c02, 1'b0, "tie_even_up");
    issue(16'h3c00, 16'hb800, 16'h3800, 1'b0, "one_minus_half");
    issue(16'hbc00, 16'hbc00, 16'hc000, 1'b0, "neg_add");
    issue(16'h0200, 16'h0200, 16'h0400, 1'b0, "sub_to_normal");
    issue(16'h0001, 16'h8001, 16'h0000, 1'b0, "sub_cancel");
    issue(16'h0001, 16'h0001, 16'h0002, 1'b0, "sub_add");
    issue(16'h0400, 16'h8001, 16'h03ff, 1'b0, "normal_to_sub");
    issue(16'h0000, 16'h0000, 16'h0000, 1'b0, "pz_pz");
    issue(16'h8000, 16'h8000, 16'h8000, 1'b0, "nz_nz");
    issue(16'h0000, 16'h8000, 16'h0000, 1'b0, "pz_nz");
    issue(16'h7c00, 16'hfc00, 16'h7e00, 1'b0, "inf_minus_inf");
    issue(16'h7c00, 16'h3c00, 16'h7c00, 1'b0, "inf_plus_finite");
    issue(16'h3c00, 16'hfc00, 16'hfc00, 1'b0, "finite_plus_ninf");
    issue(16'h7c00, 16'h7c00, 16'h7c00, 1'b0, "inf_plus_inf");
    issue(16'h7e00, 16'h0000, 16'h7e00, 1'b0, "nan_a");
    issue(16'h3c00, 16'h7e01, 16'h7e00, 1'b0, "nan_b");

    // Leave Overflow high, then reset between edges with 1+1 on the inputs.
    issue(16'h7bff, 16'h7bff, POS_OVF, 1'b1, "pre_reset_ovf");
    @(negedge Clk);
    A = 16'h3c00;
    B = 16'h3c00;
    #2 Rst = 1'b1;
    #1 check("reset_mid_cycle", {Sum, Overflow}, {16'h0000, 1'b0});
    @(posedge Clk);
    #1 check("reset_mid_hold", {Sum, Overflow}, {16'h0000, 1'b0});
    @(negedge Clk);
    Rst = 1'b0;
    e.sum = 16'h4000;
    e.ovf = 1'b0;
    e.tag = "after_reset";
    sb_q.push_back(e);
    @(posedge Clk);
    #1 compare_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
